pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_if.sv | 27 ++
 rtl/pipe_ctrl_mc_counter.sv | 58 +++++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
package pipe_ctrl_pkg;

    localparam int          REG_BUS_W = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Stall bit positions: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
    localparam int STB_PC     = 0;
    localparam int STB_IF_ID  = 1;
    localparam int STB_ID_EX  = 2;
    localparam int STB_EX_MEM = 3;
    localparam int STB_MEM_WB = 4;
    localparam int STB_WB     = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } ctrl_state_e;

    // A requested latency of zero behaves as a single-cycle op.
    function automatic logic [5:0] mc_len(input logic [5:0] n);
        return (n == 6'd0) ? 6'd1 : n;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages (master) and the controller (slave).
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        mem_req;
    logic        mem_ack;
    logic        excp_valid;
    logic [31:0] excp_vector;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_mc_done;
    logic        mem_timeout;

    modport master (
        output stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack,
               excp_valid, excp_vector,
        input  stall, flush, new_pc, ex_mc_done, mem_timeout
    );

    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack,
               excp_valid, excp_vector,
        output stall, flush, new_pc, ex_mc_done, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// Multi-cycle EX op counter: load a latency, stay busy for the remaining cycles,
// pulse expire during the final stall cycle of the op.
module pipe_ctrl_mc_counter
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [5:0] len,
    output logic       busy,
    output logic       expire
);

    logic       busy_q, busy_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] len_eff;

    // cnt_q holds the stall cycles still owed, including the current one.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        expire  = 1'b0;
        len_eff = mc_len(len);
        if (clr) begin
            busy_d = 1'b0;
            cnt_d  = 6'd0;
        end else if (busy_q) begin
            if (cnt_q == 6'd1) begin
                busy_d = 1'b0;
                cnt_d  = 6'd0;
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q - 6'd1;
            end
        end else if (load) begin
            if (len_eff == 6'd1) begin
                expire = 1'b1;
            end else begin
                busy_d = 1'b1;
                cnt_d  = len_eff - 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= 6'd0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory wait with timeout, multi-cycle EX ops,
// exception redirect.
//   state       | meaning
//   ST_RUN      | normal flow; ID/EX stalls, new memory access may begin waiting
//   ST_MEM_WAIT | memory access outstanding; MEM stall until ack or timeout
//   ST_FLUSH    | one quiet cycle after a redirect; all inputs ignored
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          MEM_TIMEOUT = 255,
    parameter logic [31:0] TIMEOUT_VEC = 32'h0000_0040
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);

    ctrl_state_e          state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic                 mem_timeout_q, mem_timeout_d;
    logic                 done_pend_q, done_pend_d;

    logic                 mem_stall;
    logic                 flush_c;
    logic [REG_BUS_W-1:0] new_pc_c;
    logic                 ex_clr;
    logic                 ex_load;
    logic                 ex_busy;
    logic                 ex_expire;
    logic                 ex_stall;
    logic                 done_now;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        mem_timeout_d = mem_timeout_q;
        mem_stall     = 1'b0;
        flush_c       = 1'b0;
        new_pc_c      = ZERO_WORD;
        ex_clr        = 1'b0;
        case (state_q)
            ST_RUN: begin
                timer_d = 8'd0;
                if (bus.excp_valid) begin
                    flush_c  = 1'b1;
                    new_pc_c = bus.excp_vector;
                    ex_clr   = 1'b1;
                    state_d  = ST_FLUSH;
                end else if (bus.mem_req && !bus.mem_ack) begin
                    mem_stall = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.excp_valid) begin
                    flush_c  = 1'b1;
                    new_pc_c = bus.excp_vector;
                    ex_clr   = 1'b1;
                    timer_d  = 8'd0;
                    state_d  = ST_FLUSH;
                    // The redirect goes to the handler, but the timeout still happened.
                    if (!bus.mem_ack && timer_q == TIMER_LAST) mem_timeout_d = 1'b1;
                end else if (bus.mem_ack) begin
                    timer_d = 8'd0;
                    state_d = ST_RUN;
                end else if (timer_q == TIMER_LAST) begin
                    flush_c       = 1'b1;
                    new_pc_c      = TIMEOUT_VEC;
                    mem_timeout_d = 1'b1;
                    ex_clr        = 1'b1;
                    timer_d       = 8'd0;
                    state_d       = ST_FLUSH;
                end else begin
                    mem_stall = 1'b1;
                    timer_d   = timer_q + 8'd1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                timer_d = 8'd0;
            end
        endcase
    end

    // A finished op whose done pulse is still held back by a MEM stall blocks
    // new starts, so each op gets its own pulse.
    always_comb begin
        done_now = done_pend_q && !mem_stall && !flush_c && (state_q != ST_FLUSH);
        ex_load  = bus.ex_mc_start && !ex_busy && (!done_pend_q || done_now)
                   && !flush_c && (state_q != ST_FLUSH);
        ex_stall = ex_load || ex_busy;
    end

    always_comb begin
        done_pend_d = done_pend_q;
        if (ex_clr)         done_pend_d = 1'b0;
        else if (ex_expire) done_pend_d = 1'b1;
        else if (done_now)  done_pend_d = 1'b0;
    end

    pipe_ctrl_mc_counter u_ex_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (ex_clr),
        .load   (ex_load),
        .len    (bus.ex_mc_cycles),
        .busy   (ex_busy),
        .expire (ex_expire)
    );

    always_comb begin
        bus.stall      = STALL_NONE;
        bus.flush      = 1'b0;
        bus.new_pc     = ZERO_WORD;
        bus.ex_mc_done = 1'b0;
        if (!rst) begin
            bus.flush      = flush_c;
            bus.new_pc     = new_pc_c;
            bus.ex_mc_done = done_now;
            if (!flush_c && state_q != ST_FLUSH) begin
                if (mem_stall)            bus.stall = STALL_MEM;
                else if (ex_stall)        bus.stall = STALL_EX;
                else if (bus.stallreq_id) bus.stall = STALL_ID;
            end
        end
    end

    assign bus.mem_timeout = mem_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            timer_q       <= 8'd0;
            mem_timeout_q <= 1'b0;
            done_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mem_timeout_q <= mem_timeout_d;
            done_pend_q   <= done_pend_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic,
// expectations from a cycle-indexed behavioural model.
module tb_pipe_ctrl;

    localparam int          MT = 4;
    localparam logic [31:0] TV = 32'h0000_0040;

    logic clk = 1'b0;
    logic rst;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MEM_TIMEOUT(MT), .TIMEOUT_VEC(TV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        done;
        logic        mt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: absolute cycle numbers mark when a memory wait began and when an
    // EX op's stall window ends.
    int cyc       = 0;
    bit m_inmem   = 0;
    int m_mstart  = 0;
    bit m_inflush = 0;
    bit m_mt      = 0;
    bit op_valid  = 0;
    int op_end    = 0;

    task automatic step(input bit r, input bit id, input bit st, input int n,
                        input bit mr, input bit ma, input bit ev, input logic [31:0] vec);
        exp_t e;
        bit   mstall = 0;
        bit   ex_st  = 0;
        bit   fl     = 0;
        bit   done   = 0;
        logic [31:0] pc = 32'h0;
        @(negedge clk);
        rst              = r;
        bus.stallreq_id  = id;
        bus.ex_mc_start  = st;
        bus.ex_mc_cycles = 6'(n);
        bus.mem_req      = mr;
        bus.mem_ack      = ma;
        bus.excp_valid   = ev;
        bus.excp_vector  = vec;
        e.stall = 6'b0; e.flush = 1'b0; e.pc = 32'h0; e.done = 1'b0;
        e.mt    = m_mt; e.cyc = cyc;
        if (r) begin
            m_inmem = 0; m_inflush = 0; m_mt = 0; op_valid = 0;
        end else if (m_inflush) begin
            m_inflush = 0;
        end else begin
            if (ev) begin
                fl = 1; pc = vec;
                if (m_inmem && !ma && (cyc - m_mstart) == MT) m_mt = 1;
            end else if (m_inmem) begin
                if (ma) m_inmem = 0;
                else if ((cyc - m_mstart) == MT) begin fl = 1; pc = TV; m_mt = 1; end
                else mstall = 1;
            end else if (mr && !ma) begin
                mstall = 1; m_inmem = 1; m_mstart = cyc;
            end
            if (fl) begin
                m_inmem = 0; m_inflush = 1; op_valid = 0;
            end else begin
                done = op_valid && (cyc >= op_end) && !mstall;
                if (done) op_valid = 0;
                ex_st = op_valid && (cyc < op_end);
                if (st && !op_valid) begin
                    op_valid = 1;
                    op_end   = cyc + ((n % 64 == 0) ? 1 : (n % 64));
                    ex_st    = 1;
                end
            end
            e.flush = fl; e.pc = pc; e.done = done;
            e.stall = fl     ? 6'b000000 :
                      mstall ? 6'b011111 :
                      ex_st  ? 6'b001111 :
                      id     ? 6'b000111 : 6'b000000;
        end
        sb.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv, input int c);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, act, expv);
        end
    endtask

    exp_t m_e;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                m_e = sb.pop_front();
                chk("stall",       32'(bus.stall),       32'(m_e.stall), m_e.cyc);
                chk("flush",       32'(bus.flush),       32'(m_e.flush), m_e.cyc);
                chk("new_pc",      bus.new_pc,           m_e.pc,         m_e.cyc);
                chk("ex_mc_done",  32'(bus.ex_mc_done),  32'(m_e.done),  m_e.cyc);
                chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_e.mt),    m_e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.stallreq_id = 0; bus.ex_mc_start = 0; bus.ex_mc_cycles = 0;
        bus.mem_req = 0; bus.mem_ack = 0; bus.excp_valid = 0; bus.excp_vector = 0;

        // Reset with busy inputs: outputs must stay quiet.
        step(1, 1, 1, 5, 1, 0, 1, 32'h1234);
        step(1, 1, 0, 0, 1, 0, 0, 32'h0);
        idle(2);
        // Load-use stall for one cycle.
        step(0, 1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);
        // N=4 op, second start during busy ignored.
        step(0, 0, 1, 4, 0, 0, 0, 32'h0);
        idle(1);
        step(0, 0, 1, 4, 0, 0, 0, 32'h0);
        idle(4);
        // Memory wait of 3 cycles hides an N=2 op; done after ack.
        step(0, 0, 0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 2, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 1, 0, 32'h0);
        idle(2);
        // N=10 op aborted by exception; FLUSH ignores ID stall.
        step(0, 0, 1, 10, 0, 0, 0, 32'h0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0180);
        step(0, 1, 1, 3, 1, 0, 0, 32'h0);
        idle(12);
        // Memory timeout, sticky flag.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0, 32'h0);
        idle(3);
        // Zero latency op behaves as N=1.
        step(0, 0, 1, 0, 0, 0, 0, 32'h0);
        idle(2);
        // Reset mid-wait and mid-op.
        step(0, 0, 1, 6, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 1, 0, 0, 32'h0);
        idle(10);

        for (int i = 0; i < 3000; i++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0,
                 n,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom);
        end

        @(negedge clk);
        #4;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
